// File: rtl/keypad_entry.sv
// Keypad scanner and three-digit decimal entry.
// Drives one 4x4 keypad row at a time (active-low), debounces a single
// pressed key over DEB_SCANS row-sample points, and folds accepted keys
// into a 0..999 value being typed (Live_Data) and a committed value
// (Entry_Data). DEB_SCANS is expected to be at least 2 and ROW_TICKS at
// least 3, so the synchronized column value settles before each sample.
`timescale 1ns/1ps

module keypad_entry #(
  parameter int ROW_TICKS = 100_000,
  parameter int DEB_SCANS = 10
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [3:0]  COL,
  output logic [3:0]  ROW,
  output logic [3:0]  Key_Code,
  output logic        Key_Strobe,
  output logic [15:0] Live_Data,
  output logic [15:0] Entry_Data,
  output logic        Entry_Valid
);

  localparam int TICK_W = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
  localparam int CNT_W  = $clog2(DEB_SCANS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ROW_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEB_SCANS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        col_meta_q, col_sync_q;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        row_q, row_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]  rel_q, rel_d;
  logic [1:0]        key_row_q, key_row_d;
  logic [1:0]        key_col_q, key_col_d;
  logic [3:0]        code_q, code_d;
  logic              strobe_q, strobe_d;
  logic [9:0]        live_q, live_d;
  logic [9:0]        entry_q, entry_d;
  logic              valid_q, valid_d;

  logic              sample;
  logic              col_single;
  logic              col_idle;
  logic [1:0]        col_idx;
  logic [3:0]        row_rot;
  logic [3:0]        key_hit;
  logic [CNT_W-1:0]  match_inc;
  logic [CNT_W-1:0]  rel_inc;

  // Position (0..3) of the single low bit of an active-low one-hot vector.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    case (v)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Keypad legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D with * = E, # = F.
  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  // Shift one decimal digit into the typed value; callers ensure live < 100.
  function automatic logic [9:0] digit_append(input logic [9:0] live, input logic [3:0] d);
    return live * 10'd10 + {6'b0, d};
  endfunction

  assign sample     = (tick_q == TICK_LAST);
  assign tick_d     = sample ? '0 : tick_q + 1'b1;
  assign col_single = $onehot(~col_sync_q);
  assign col_idle   = (col_sync_q == 4'b1111);
  assign col_idx    = low_idx(col_sync_q);
  assign row_rot    = {row_q[2:0], row_q[3]};
  assign key_hit    = key_lookup(key_row_q, key_col_q);
  assign match_inc  = match_q + 1'b1;
  assign rel_inc    = rel_q + 1'b1;

  // Two-flop synchronizer for the asynchronous, pulled-up column inputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      col_meta_q <= 4'b1111;
      col_sync_q <= 4'b1111;
    end else begin
      col_meta_q <= COL;
      col_sync_q <= col_meta_q;
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= SCAN;
      tick_q    <= '0;
      row_q     <= 4'b1110;
      match_q   <= '0;
      rel_q     <= '0;
      key_row_q <= 2'd0;
      key_col_q <= 2'd0;
      code_q    <= 4'h0;
      strobe_q  <= 1'b0;
      live_q    <= '0;
      entry_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      row_q     <= row_d;
      match_q   <= match_d;
      rel_q     <= rel_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      code_q    <= code_d;
      strobe_q  <= strobe_d;
      live_q    <= live_d;
      entry_q   <= entry_d;
      valid_q   <= valid_d;
    end
  end

  // Scan/debounce FSM and key processing, evaluated only at sample points.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    match_d   = match_q;
    rel_d     = rel_q;
    key_row_d = key_row_q;
    key_col_d = key_col_q;
    code_d    = code_q;
    strobe_d  = 1'b0;
    live_d    = live_q;
    entry_d   = entry_q;
    valid_d   = 1'b0;

    if (sample) begin
      case (state_q)
        SCAN: begin
          if (col_single) begin
            key_row_d = low_idx(row_q);
            key_col_d = col_idx;
            match_d   = CNT_W'(1);
            state_d   = DEBOUNCE;
          end else begin
            row_d = row_rot;
          end
        end
        DEBOUNCE: begin
          if (col_single && (col_idx == key_col_q)) begin
            if (match_inc == CNT_DONE) begin
              match_d  = '0;
              state_d  = HELD;
              code_d   = key_hit;
              strobe_d = 1'b1;
              if (key_hit <= 4'd9) begin
                if (live_q < 10'd100) live_d = digit_append(live_q, key_hit);
              end else begin
                case (key_hit)
                  4'hB: live_d = live_q / 10'd10;
                  4'hE: live_d = '0;
                  4'hF: begin
                    entry_d = live_q;
                    valid_d = 1'b1;
                    live_d  = '0;
                  end
                  default: ;
                endcase
              end
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
            state_d = SCAN;
            row_d   = row_rot;
          end
        end
        HELD: begin
          if (col_idle) begin
            rel_d   = CNT_W'(1);
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (col_idle) begin
            if (rel_inc == CNT_DONE) begin
              rel_d   = '0;
              state_d = SCAN;
              row_d   = row_rot;
            end else begin
              rel_d = rel_inc;
            end
          end else begin
            rel_d   = '0;
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign ROW         = row_q;
  assign Key_Code    = code_q;
  assign Key_Strobe  = strobe_q;
  assign Live_Data   = {6'b0, live_q};
  assign Entry_Data  = {6'b0, entry_q};
  assign Entry_Valid = valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: keypad model, scoreboard of expected key results.
`timescale 1ns/1ps

module tb_keypad_entry;

  localparam int RT = 4;
  localparam int DS = 3;
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD};

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] live;
    logic [15:0] entry;
    logic        valid;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  col_drv;
  logic [3:0]  ROW;
  logic [3:0]  Key_Code;
  logic        Key_Strobe;
  logic [15:0] Live_Data;
  logic [15:0] Entry_Data;
  logic        Entry_Valid;

  logic [15:0] mask = '0;
  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_strobe = 0;
  int          n_push = 0;
  int          strobe_cyc = 0;
  int          cyc = 0;
  logic        prev_strobe = 1'b0;
  int          m_live = 0;
  int          m_entry = 0;

  always #5 Clk = ~Clk;

  keypad_entry #(.ROW_TICKS(RT), .DEB_SCANS(DS)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .COL(col_drv), .ROW(ROW),
    .Key_Code(Key_Code), .Key_Strobe(Key_Strobe), .Live_Data(Live_Data),
    .Entry_Data(Entry_Data), .Entry_Valid(Entry_Valid));

  // Pressed switches connect a driven (low) row to their column.
  always_comb begin
    col_drv = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!ROW[r])
        for (int c = 0; c < 4; c++)
          if (mask[r*4 + c]) col_drv[c] = 1'b0;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one accepted key.
  function automatic exp_t model(input logic [3:0] code);
    exp_t e;
    e.code  = code;
    e.valid = 1'b0;
    if (code <= 4'd9) begin
      if (m_live < 100) m_live = m_live * 10 + int'(code);
    end else if (code == 4'hB) begin
      m_live = m_live / 10;
    end else if (code == 4'hE) begin
      m_live = 0;
    end else if (code == 4'hF) begin
      m_entry = m_live;
      m_live  = 0;
      e.valid = 1'b1;
    end
    e.live  = 16'(m_live);
    e.entry = 16'(m_entry);
    return e;
  endfunction

  // Monitor: every strobe is matched against the oldest expected result.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (Key_Strobe) begin
        n_strobe   <= n_strobe + 1;
        strobe_cyc <= cyc;
        check("strobe_width", 32'(prev_strobe), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check("key_code", 32'(Key_Code), 32'(mon_e.code));
          check("live_data", 32'(Live_Data), 32'(mon_e.live));
          check("entry_data", 32'(Entry_Data), 32'(mon_e.entry));
          check("entry_valid", 32'(Entry_Valid), 32'(mon_e.valid));
        end
      end else if (Entry_Valid) begin
        check("valid_without_strobe", 32'(Key_Strobe), 32'd1);
      end
    end
    prev_strobe <= Key_Strobe;
  end

  task automatic key_down(input logic [3:0] code);
    for (int i = 0; i < 16; i++)
      if (KEYMAP[i] == code) mask[i] = 1'b1;
  endtask

  task automatic key_up();
    mask = '0;
  endtask

  task automatic wait_strobe(input int start);
    int n = 0;
    while (n_strobe == start && n < 300) begin
      @(negedge Clk);
      n++;
    end
    check("strobe_seen", 32'(n < 300), 32'd1);
  endtask

  task automatic wait_row(input logic [3:0] r);
    int n = 0;
    while (ROW == r && n < 100) begin @(negedge Clk); n++; end
    while (ROW != r && n < 100) begin @(negedge Clk); n++; end
    if (n >= 100) check("wait_row_timeout", 32'(n), 32'd0);
  endtask

  task automatic press(input logic [3:0] code);
    int start;
    sb.push_back(model(code));
    n_push++;
    start = n_strobe;
    key_down(code);
    wait_strobe(start);
    repeat (8) @(negedge Clk);
    key_up();
    repeat (40) @(negedge Clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row"}, 32'(ROW), 32'hE);
    check({tag, "_code"}, 32'(Key_Code), 32'd0);
    check({tag, "_strobe"}, 32'(Key_Strobe), 32'd0);
    check({tag, "_live"}, 32'(Live_Data), 32'd0);
    check({tag, "_entry"}, 32'(Entry_Data), 32'd0);
    check({tag, "_valid"}, 32'(Entry_Valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int cap;
    int rel_cyc;

    repeat (3) @(negedge Clk);
    check_reset_outputs("reset");
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Clean entry and commit.
    press(4'h1); press(4'h2); press(4'h3);
    check("live_123", 32'(Live_Data), 32'd123);
    press(4'hF);
    check("entry_123", 32'(Entry_Data), 32'd123);
    check("live_after_commit", 32'(Live_Data), 32'd0);

    // Fourth digit ignored; function keys.
    s0 = n_strobe;
    press(4'h4); press(4'h5); press(4'h6); press(4'h7);
    check("live_456", 32'(Live_Data), 32'd456);
    check("code_7", 32'(Key_Code), 32'd7);
    check("strobes_4", 32'(n_strobe - s0), 32'd4);
    press(4'hA); press(4'hC); press(4'hD);
    check("live_456_fkeys", 32'(Live_Data), 32'd456);
    press(4'hB); press(4'h0); press(4'hF);
    check("entry_450", 32'(Entry_Data), 32'd450);

    // Bouncing '5': seen at one sample point, gone at the next, then stable.
    wait_row(4'b1101);
    @(negedge Clk);
    key_down(4'h5);
    repeat (4) @(negedge Clk);
    key_up();
    wait_row(4'b1101);
    @(negedge Clk);
    sb.push_back(model(4'h5));
    n_push++;
    s0  = n_strobe;
    cap = cyc + 1;
    key_down(4'h5);
    wait_strobe(s0);
    check("debounce_latency", 32'(strobe_cyc - cap), 32'd10);
    repeat (8) @(negedge Clk);
    key_up();
    repeat (40) @(negedge Clk);
    press(4'hE);

    // Two keys in one row: ignored, scanning continues.
    mask[0] = 1'b1;
    mask[1] = 1'b1;
    s0 = n_strobe;
    repeat (40) @(negedge Clk);
    check("multi_no_strobe", 32'(n_strobe - s0), 32'd0);
    wait_row(4'b1110);
    repeat (4) @(negedge Clk);
    check("multi_rotate", 32'(ROW), 32'hD);
    key_up();
    repeat (20) @(negedge Clk);

    // Long hold of '8': one strobe, row frozen until release is debounced.
    sb.push_back(model(4'h8));
    n_push++;
    s0 = n_strobe;
    key_down(4'h8);
    wait_strobe(s0);
    for (int i = 0; i < 10; i++) begin
      repeat (20) @(negedge Clk);
      check("held_row", 32'(ROW), 32'hB);
    end
    key_up();
    repeat (5) @(negedge Clk);
    check("release_row_frozen", 32'(ROW), 32'hB);
    for (int i = 0; i < 40 && ROW == 4'b1011; i++) @(negedge Clk);
    check("release_rotate", 32'(ROW), 32'h7);
    repeat (20) @(negedge Clk);
    press(4'hE);

    // Backspace, clear, then reset in the middle of a press.
    press(4'h7); press(4'h8);
    check("live_78", 32'(Live_Data), 32'd78);
    press(4'hB);
    check("live_7", 32'(Live_Data), 32'd7);
    press(4'hE);
    check("live_clear", 32'(Live_Data), 32'd0);
    wait_row(4'b1011);
    key_down(4'h9);
    repeat (6) @(negedge Clk);
    #2 Reset_n = 1'b0;
    m_live  = 0;
    m_entry = 0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    rel_cyc = cyc;
    sb.push_back(model(4'h9));
    n_push++;
    s0 = n_strobe;
    wait_strobe(s0);
    check("post_reset_latency", 32'(strobe_cyc - rel_cyc), 32'd20);
    repeat (8) @(negedge Clk);
    key_up();
    repeat (40) @(negedge Clk);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("strobe_total", 32'(n_strobe), 32'(n_push));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
